// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: sync, integrating debounce, edge pulses, hold and auto-repeat.
// The release and repeat pulse ports are named release_pulse/repeat_pulse because the bare words are reserved.
module debounce_bank #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned STABLE_N = 4,
    parameter int unsigned HOLD_N   = 200,
    parameter int unsigned REPEAT_N = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_N + 1);
    localparam int unsigned HW = (HOLD_N > 0) ? $clog2(HOLD_N + 1) : 1;
    localparam int unsigned RW = (REPEAT_N > 0) ? $clog2(REPEAT_N + 1) : 1;

    logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] rel_q, rel_d;
    logic [N_CH-1:0] hold_q, hold_d;
    logic [N_CH-1:0] rep_q, rep_d;

    logic [CW-1:0] cnt_q  [N_CH];
    logic [CW-1:0] cnt_d  [N_CH];
    logic [HW-1:0] hcnt_q [N_CH];
    logic [HW-1:0] hcnt_d [N_CH];
    logic [RW-1:0] rcnt_q [N_CH];
    logic [RW-1:0] rcnt_d [N_CH];

    // Next-state: synchroniser, prescaler, then per-channel debounce/hold/repeat on ticks only
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        rep_d   = '0;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(STABLE_N - 1)) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    press_d[i] = sync2_q[i];
                    rel_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end

                // Hold/repeat only track ticks spent at level 1; a falling level wipes them
                if (HOLD_N != 0) begin
                    if (rel_d[i]) begin
                        hcnt_d[i] = '0;
                        hold_d[i] = 1'b0;
                        rcnt_d[i] = '0;
                    end else if (level_q[i]) begin
                        if (hcnt_q[i] != HW'(HOLD_N)) begin
                            hcnt_d[i] = hcnt_q[i] + HW'(1);
                        end
                        if (!hold_q[i]) begin
                            if (hcnt_q[i] == HW'(HOLD_N - 1)) begin
                                hold_d[i] = 1'b1;
                                rep_d[i]  = 1'b1;
                                rcnt_d[i] = '0;
                            end
                        end else if (REPEAT_N != 0) begin
                            if (rcnt_q[i] == RW'(REPEAT_N - 1)) begin
                                rep_d[i]  = 1'b1;
                                rcnt_d[i] = '0;
                            end else begin
                                rcnt_d[i] = rcnt_q[i] + RW'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            cnt_q   <= '{default: '0};
            hcnt_q  <= '{default: '0};
            rcnt_q  <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign hold          = hold_q;
    assign repeat_pulse  = rep_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: main 2-channel instance plus a fast TICK_DIV=1/STABLE_N=1 instance.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] level, press, rel, hold, rep;
    logic [0:0] btn7;
    logic [0:0] level7, press7, rel7, hold7, rep7;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int   press_n [2];
    int   rel_n   [2];
    int   rep_n   [2];
    int   first_press [2];
    int   first_hold0;
    int   t0;
    bit   press_wide, both_flag, coinc, any_act;
    logic [1:0] prev_press;
    logic prev_hold0, rel_hold0, rel_prevhold0;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(2), .TICK_DIV(4), .STABLE_N(3), .HOLD_N(5), .REPEAT_N(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn), .level(level), .press(press),
        .release_pulse(rel), .hold(hold), .repeat_pulse(rep)
    );

    debounce_bank #(.N_CH(1), .TICK_DIV(1), .STABLE_N(1), .HOLD_N(5), .REPEAT_N(2)) u_fast (
        .clk(clk), .rst_n(rst_n), .btn_in(btn7), .level(level7), .press(press7),
        .release_pulse(rel7), .hold(hold7), .repeat_pulse(rep7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 2; c++) begin
            press_n[c] = 0;
            rel_n[c] = 0;
            rep_n[c] = 0;
            first_press[c] = -1;
        end
        first_hold0 = -1;
        press_wide = 0;
        both_flag = 0;
        coinc = 0;
        any_act = 0;
        rel_hold0 = 1'b1;
        rel_prevhold0 = 1'b0;
    endtask

    // Advance one clock, sample 1 time unit after the edge and accumulate events
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (press[c]) begin
                press_n[c]++;
                if (first_press[c] < 0) first_press[c] = cyc;
                if (prev_press[c]) press_wide = 1;
            end
            if (rel[c]) rel_n[c]++;
            if (rep[c]) rep_n[c]++;
            if (press[c] && rel[c]) both_flag = 1;
        end
        if (press[1] && rel[0]) coinc = 1;
        if (rel[0]) begin
            rel_hold0 = hold[0];
            rel_prevhold0 = prev_hold0;
        end
        if (hold[0] && first_hold0 < 0) first_hold0 = cyc;
        if (|{level, press, rel, hold, rep}) any_act = 1;
        prev_press = press;
        prev_hold0 = hold[0];
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        btn = 2'b00;
        btn7 = 1'b0;
        prev_press = 2'b00;
        prev_hold0 = 1'b0;
        clr();

        // Reset state
        run(3);
        chk("reset_main_outputs", 32'({level, press, rel, hold, rep}), 0);
        chk("reset_fast_outputs", 32'({level7, press7, rel7, hold7, rep7}), 0);

        // 1: idle after reset release
        rst_n = 1'b1;
        clr();
        run(100);
        chk("idle_no_activity", 32'(any_act), 0);

        // 2: press channel 0
        clr();
        btn = 2'b01;
        t0 = cyc;
        run(20);
        chk("t2_press0_count", 32'(press_n[0]), 1);
        chk("t2_press_latency_le14", 32'((first_press[0] - t0) <= 14), 1);
        chk("t2_press_latency_ge11", 32'((first_press[0] - t0) >= 11), 1);
        chk("t2_press_one_clk", 32'(press_wide), 0);
        chk("t2_level", 32'(level), 1);
        chk("t2_ch1_quiet", 32'(press_n[1] + rel_n[1]), 0);

        btn = 2'b00;
        clr();
        run(30);
        chk("t2_release0_count", 32'(rel_n[0]), 1);
        chk("t2_level_low", 32'(level), 0);

        // 3: bounce rejection
        clr();
        for (int k = 0; k < 15; k++) begin
            btn[0] = ~btn[0];
            run(4);
        end
        btn = 2'b00;
        run(20);
        chk("t3_no_press", 32'(press_n[0]), 0);
        chk("t3_no_release", 32'(rel_n[0]), 0);
        chk("t3_level_low", 32'(level), 0);

        // 4: long press with hold and auto-repeat
        clr();
        btn = 2'b01;
        for (int k = 0; k < 40 && first_press[0] < 0; k++) step();
        chk("t4_press_seen", 32'(first_press[0] >= 0), 1);
        run(80);
        chk("t4_hold_5_ticks", 32'(first_hold0 - first_press[0]), 20);
        chk("t4_repeat_count", 32'(rep_n[0]), 8);
        chk("t4_hold_high", 32'(hold), 1);
        btn = 2'b00;
        clr();
        run(20);
        chk("t4_release_count", 32'(rel_n[0]), 1);
        chk("t4_hold_low_at_release", 32'(rel_hold0), 0);
        chk("t4_hold_high_before_release", 32'(rel_prevhold0), 1);
        chk("t4_hold_end", 32'(hold), 0);

        // 5: simultaneous events on both channels
        btn = 2'b01;
        run(30);
        chk("t5_level_01", 32'(level), 1);
        clr();
        btn = 2'b10;
        run(20);
        chk("t5_coincident", 32'(coinc), 1);
        chk("t5_press1_count", 32'(press_n[1]), 1);
        chk("t5_release0_count", 32'(rel_n[0]), 1);
        chk("t5_never_both", 32'(both_flag), 0);
        chk("t5_level_10", 32'(level), 2);

        // 6: reset while holding
        clr();
        btn = 2'b01;
        for (int k = 0; k < 100 && first_hold0 < 0; k++) step();
        chk("t6_hold_reached", 32'(hold[0]), 1);
        rst_n = 1'b0;
        step();
        chk("t6_reset_clears", 32'({level, press, rel, hold, rep}), 0);
        rst_n = 1'b1;
        clr();
        t0 = cyc;
        run(20);
        chk("t6_fresh_press", 32'(press_n[0]), 1);
        chk("t6_press_latency_le14", 32'((first_press[0] - t0) <= 14), 1);
        chk("t6_no_release", 32'(rel_n[0]), 0);
        chk("t6_level", 32'(level), 1);

        // 7: one-clk pulse through the fast instance
        btn7 = 1'b1;
        step();
        btn7 = 1'b0;
        chk("t7_e1_level", 32'(level7), 0);
        step();
        chk("t7_e2_level", 32'(level7), 0);
        step();
        chk("t7_e3_level", 32'(level7), 1);
        chk("t7_e3_press", 32'(press7), 1);
        chk("t7_e3_release", 32'(rel7), 0);
        step();
        chk("t7_e4_level", 32'(level7), 0);
        chk("t7_e4_press", 32'(press7), 0);
        chk("t7_e4_release", 32'(rel7), 1);
        step();
        chk("t7_e5_release", 32'(rel7), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
